// File: rtl/rm_violation_collector.sv
// rm_violation_collector: turns each new rising edge on the per-rule monitor vector into one
// {rule id, timestamp} record queued for the CSR/trace side. Optional macro: RM_VIOL_TIMESTAMP_EN.
module rm_violation_collector #(
    parameter int unsigned NUM_RULES  = 149,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_RULES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_RULES-1:0] monitor_i,
    input  logic [NUM_RULES-1:0] mask_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    output logic                 viol_valid_o,
    input  logic                 viol_ready_i,
    output logic [ID_WIDTH-1:0]  viol_id_o,
    output logic [TS_WIDTH-1:0]  viol_ts_o,
    output logic [15:0]          drop_cnt_o,
    output logic                 irq_o
);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned DROP_W = 16;

    logic [NUM_RULES-1:0] r_prev;
    logic [NUM_RULES-1:0] r_pending;
    logic [NUM_RULES-1:0] w_edge;
    logic [NUM_RULES-1:0] w_push_mask;
    logic [NUM_RULES-1:0] w_lost;
    logic [ID_WIDTH-1:0]  w_sel_idx;
    logic                 w_any_pend;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic [ID_WIDTH-1:0]  r_mem_id [FIFO_DEPTH];
    logic [DROP_W-1:0]    r_drop_cnt;
    logic                 r_drop_sticky;
    logic                 r_irq;

    assign w_edge     = monitor_i & ~r_prev & mask_i & {NUM_RULES{enable_i}};
    assign w_any_pend = |r_pending;

    // Fixed-priority scan: lowest pending index wins
    always_comb begin
        w_sel_idx = '0;
        for (int k = int'(NUM_RULES) - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_sel_idx = ID_WIDTH'(k);
            end
        end
    end

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop       = ~w_empty & viol_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push      = w_any_pend & (~w_full | w_pop);
    assign w_push_mask = w_push ? (NUM_RULES'(1) << w_sel_idx) : '0;
    assign w_lost      = w_edge & r_pending & ~w_push_mask;

    // prev samples unconditionally so rules held high across a clear do not re-fire
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev <= monitor_i;
            if (clear_i) begin
                r_pending <= '0;
            end else begin
                r_pending <= (r_pending & ~w_push_mask) | w_edge;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_id[i] <= '0;
            end
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem_id[r_wptr[AW-1:0]] <= w_sel_idx;
                r_wptr                   <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    // Several lost edges in one cycle count as a single drop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt    <= '0;
            r_drop_sticky <= 1'b0;
        end else if (clear_i) begin
            r_drop_cnt    <= '0;
            r_drop_sticky <= 1'b0;
        end else if (|w_lost) begin
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            r_drop_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ~w_empty | r_drop_sticky;
        end
    end

`ifdef RM_VIOL_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts_cnt;
    logic [TS_WIDTH-1:0] r_mem_ts [FIFO_DEPTH];

    // Free-running cycle stamp, deliberately untouched by clear_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ts_cnt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_ts[i] <= '0;
            end
        end else if (!clear_i && w_push) begin
            r_mem_ts[r_wptr[AW-1:0]] <= r_ts_cnt;
        end
    end

    assign viol_ts_o = r_mem_ts[r_rptr[AW-1:0]];
`else
    assign viol_ts_o = '0;
`endif

    assign viol_valid_o = ~w_empty;
    assign viol_id_o    = r_mem_id[r_rptr[AW-1:0]];
    assign drop_cnt_o   = r_drop_cnt;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_rm_violation_collector.sv
// Self-checking bench for rm_violation_collector: directed table and sequences plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_rm_violation_collector;
    localparam int NR    = 149;
    localparam int DEPTH = 8;
`ifdef RM_VIOL_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NR-1:0] mon;
    logic [NR-1:0] mask;
    logic          en;
    logic          clr;
    logic          rdy;
    logic          viol_valid_o;
    logic [7:0]    viol_id_o;
    logic [31:0]   viol_ts_o;
    logic [15:0]   drop_cnt_o;
    logic          irq_o;

    always #5 clk_i = ~clk_i;

    rm_violation_collector dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .monitor_i    (mon),
        .mask_i       (mask),
        .enable_i     (en),
        .clear_i      (clr),
        .viol_valid_o (viol_valid_o),
        .viol_ready_i (rdy),
        .viol_id_o    (viol_id_o),
        .viol_ts_o    (viol_ts_o),
        .drop_cnt_o   (drop_cnt_o),
        .irq_o        (irq_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    typedef struct {
        int          id;
        longint      ts;
    } rec_t;
    rec_t        m_q[$];
    bit          m_prev [NR];
    bit          m_pend [NR];
    int          m_drop;
    bit          m_sticky;
    bit          m_irq;
    longint      m_ts;

    typedef struct {
        bit     m37;
        bit     ev;
        int     eid;
        longint ets;
        bit     eirq;
    } vec_t;
    vec_t tbl [18];

    int rbits [10] = '{0, 1, 2, 3, 7, 64, 100, 127, 147, 148};

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint exp_ts(input longint t);
        return TS_ON ? (t & 64'hFFFF_FFFF) : 64'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) begin
            m_prev[k] = 1'b0;
            m_pend[k] = 1'b0;
        end
        m_q.delete();
        m_drop   = 0;
        m_sticky = 1'b0;
        m_irq    = 1'b0;
        m_ts     = 0;
    endtask

    task automatic check_outputs();
        chk("valid", longint'(viol_valid_o), longint'(m_q.size() != 0));
        chk("drop_cnt", longint'(drop_cnt_o), longint'(m_drop));
        chk("irq", longint'(irq_o), longint'(m_irq));
        if (m_q.size() != 0) begin
            chk("head_id", longint'(viol_id_o), longint'(m_q[0].id));
            chk("head_ts", longint'(viol_ts_o), exp_ts(m_q[0].ts));
        end
    endtask

    // Advance the model one clock using the inputs currently applied
    task automatic model_step();
        bit valid;
        bit pop;
        bit push;
        bit lost;
        bit irq_n;
        int sel;
        bit e [NR];
        valid = (m_q.size() != 0);
        pop   = valid && rdy;
        sel   = -1;
        for (int k = 0; k < NR; k++) begin
            if (m_pend[k] && sel < 0) sel = k;
        end
        push = (sel >= 0) && ((m_q.size() < DEPTH) || pop);
        lost = 1'b0;
        for (int k = 0; k < NR; k++) begin
            e[k] = mon[k] && !m_prev[k] && mask[k] && en;
            if (e[k] && m_pend[k] && !(push && k == sel)) lost = 1'b1;
        end
        irq_n = valid || m_sticky;
        if (clr) begin
            for (int k = 0; k < NR; k++) m_pend[k] = 1'b0;
            m_q.delete();
            m_drop   = 0;
            m_sticky = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back('{id: sel, ts: m_ts});
                m_pend[sel] = 1'b0;
            end
            for (int k = 0; k < NR; k++) begin
                if (e[k]) m_pend[k] = 1'b1;
            end
            if (lost) begin
                if (m_drop < 65535) m_drop++;
                m_sticky = 1'b1;
            end
        end
        for (int k = 0; k < NR; k++) m_prev[k] = mon[k];
        m_irq = irq_n;
        m_ts  = (m_ts + 1) & 64'hFFFF_FFFF;
    endtask

    task automatic step();
        check_outputs();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, longint'(viol_valid_o), 0);
        chk({tag, "_id"}, longint'(viol_id_o), 0);
        chk({tag, "_ts"}, longint'(viol_ts_o), 0);
        chk({tag, "_drop"}, longint'(drop_cnt_o), 0);
        chk({tag, "_irq"}, longint'(irq_o), 0);
    endtask

    initial begin
        int     got[$];
        longint t0;
        mon  = '0;
        mask = '1;
        en   = 1'b1;
        clr  = 1'b0;
        rdy  = 1'b1;
        model_reset();

        for (int c = 0; c < 18; c++) begin
            tbl[c].m37  = (c >= 10);
            tbl[c].ev   = (c == 12);
            tbl[c].eid  = 37;
            tbl[c].ets  = exp_ts(11);
            tbl[c].eirq = (c == 13);
        end

        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;

        // Single edge on rule 37 in cycle 10
        for (int c = 0; c < 18; c++) begin
            mon[37] = tbl[c].m37;
            chk("tbl_valid", longint'(viol_valid_o), longint'(tbl[c].ev));
            chk("tbl_irq", longint'(irq_o), longint'(tbl[c].eirq));
            if (tbl[c].ev) begin
                chk("tbl_id", longint'(viol_id_o), longint'(tbl[c].eid));
                chk("tbl_ts", longint'(viol_ts_o), tbl[c].ets);
            end
            step();
        end
        mon[37] = 1'b0;
        repeat (4) step();

        // Priority: three simultaneous edges
        mon[5] = 1'b1; mon[100] = 1'b1; mon[148] = 1'b1;
        t0 = m_ts;
        step(); step();
        chk("prio_id0", longint'(viol_id_o), 5);
        chk("prio_ts0", longint'(viol_ts_o), exp_ts(t0 + 1));
        step();
        chk("prio_id1", longint'(viol_id_o), 100);
        chk("prio_ts1", longint'(viol_ts_o), exp_ts(t0 + 2));
        step();
        chk("prio_id2", longint'(viol_id_o), 148);
        chk("prio_ts2", longint'(viol_ts_o), exp_ts(t0 + 3));
        step();
        mon = '0;
        repeat (4) step();

        // Backpressure: 10 rules into an 8-deep FIFO
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mon[10+i] = 1'b1;
            step();
        end
        repeat (3) step();
        chk("bp_drop", longint'(drop_cnt_o), 0);
        chk("bp_valid", longint'(viol_valid_o), 1);
        chk("bp_head", longint'(viol_id_o), 10);
        rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (viol_valid_o) got.push_back(int'(viol_id_o));
            step();
        end
        chk("bp_count", longint'(got.size()), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk("bp_order", longint'(got[i]), longint'(10 + i));
        end
        mon = '0;
        repeat (3) step();

        // Drop: rule 3 re-asserts while still pending behind a full FIFO
        rdy = 1'b0;
        for (int r = 30; r <= 38; r++) mon[r] = 1'b1;
        repeat (12) step();
        mon[3] = 1'b1; step(); step();
        mon[3] = 1'b0; step();
        mon[3] = 1'b1; step(); step();
        chk("drop_cnt1", longint'(drop_cnt_o), 1);
        mon = '0;
        rdy = 1'b1;
        repeat (16) step();
        chk("drop_drained", longint'(viol_valid_o), 0);
        chk("drop_kept", longint'(drop_cnt_o), 1);
        chk("drop_irq", longint'(irq_o), 1);

        // Mask
        mask[20] = 1'b0;
        mon[20]  = 1'b1;
        repeat (5) step();
        chk("mask_no_rec", longint'(viol_valid_o), 0);
        mon[20] = 1'b0;
        mask    = '1;
        step();

        // Clear with three records queued
        rdy = 1'b0;
        mon[40] = 1'b1; mon[41] = 1'b1; mon[42] = 1'b1;
        repeat (5) step();
        chk("clr_pre_valid", longint'(viol_valid_o), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_valid", longint'(viol_valid_o), 0);
        chk("clr_drop", longint'(drop_cnt_o), 0);
        repeat (4) step();
        chk("clr_no_refire", longint'(viol_valid_o), 0);
        chk("clr_irq", longint'(irq_o), 0);
        mon = '0;
        step();

        // Asynchronous reset with four queued
        for (int r = 50; r <= 53; r++) mon[r] = 1'b1;
        repeat (6) step();
        chk("rst_pre_valid", longint'(viol_valid_o), 1);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        rdy    = 1'b1;
        step(); step();
        chk("rst_fire_valid", longint'(viol_valid_o), 1);
        chk("rst_fire_id", longint'(viol_id_o), 50);
        chk("rst_fire_ts", longint'(viol_ts_o), exp_ts(1));
        mon = '0;
        repeat (8) step();

        // Randomized traffic on a small set of colliding rules
        for (int c = 0; c < 800; c++) begin
            foreach (rbits[j]) begin
                if ($urandom_range(3) == 0) mon[rbits[j]] = ~mon[rbits[j]];
            end
            mask = '1;
            if ($urandom_range(9) == 0) mask[rbits[$urandom_range(9)]] = 1'b0;
            en  = ($urandom_range(15) != 0);
            clr = ($urandom_range(63) == 0);
            rdy = ($urandom_range(2) == 0);
            step();
        end
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rm_violation_collector.md
# rm_violation_collector

Downstream consumer of the runtime-monitor lane: samples the per-rule monitor vector produced by the lane and converts each newly asserted rule bit into a single violation record. Records are the rule index plus an optional cycle timestamp, queued in a small FIFO. They are handed to the CSR/trace side through a valid/ready handshake. Rising-edge detection, sticky pending bits, a fixed-priority scanner and drop accounting make sure no more than one record is produced per assertion.

## Interface
- NUM_RULES, 149, width of the monitor vector (one bit per LTL rule)
- FIFO_DEPTH, 8, record FIFO entries (power of two, ≥2)
- TS_WIDTH, 32, timestamp width
- ID_WIDTH, $clog2(NUM_RULES), rule index width (derived)
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- monitor_i  in  NUM_RULES  rule outputs from the lane (level signals)
- mask_i  in  NUM_RULES  1 = rule enabled for recording
- enable_i  in  1  global edge-detect enable
- clear_i  in  1  synchronous flush of pending, FIFO, drop state
- viol_valid_o  out  1  record available
- viol_ready_i  in  1  consumer accepts record
- viol_id_o  out  ID_WIDTH  rule index of head record
- viol_ts_o  out  TS_WIDTH  timestamp of head record
- drop_cnt_o  out  16  saturating count of lost assertions
- irq_o  out  1  registered interrupt

## Operation
- prev register (NUM_RULES) samples monitor_i every cycle, regardless of enable_i/mask_i.
- edge[k] = monitor_i[k] & ~prev[k] & mask_i[k] & enable_i.
- pending[k] set on edge[k]; cleared when k is pushed. A set and a clear of the same bit in one cycle: set wins (new edge re-arms).
- edge[k] while pending[k]=1 and k not pushed this cycle → assertion lost, drop_cnt_o += 1, saturating at 0xFFFF. Several lost bits in one cycle add 1 in total.
- Scanner: each cycle, if any pending bit and FIFO not full, select lowest index k, push {k, ts_cnt}, clear pending[k]. At most one push per cycle. FIFO full → pending bits hold; no drop is counted for waiting.
- ts_cnt: free-running TS_WIDTH counter, +1 every cycle, wraps to 0. It is not affected by clear_i.
- FIFO: head drives viol_id_o/viol_ts_o. A pop happens when viol_valid_o & viol_ready_i. A push and a pop in the same cycle are both allowed when full; count is unchanged.
- irq_o is registered: next = FIFO non-empty | drop_sticky. drop_sticky sets when drop_cnt_o increments and clears only on clear_i.
- clear_i: pending, FIFO pointers, drop_cnt_o and drop_sticky go to 0 next cycle; prev keeps sampling, so rules that stay high do not re-fire. clear_i has priority over same-cycle edges, pushes and pops.
- Holding viol_valid_o: once asserted, it stays high and the head stays stable until it is popped or clear_i is applied.

## Timing
- Reset values: viol_valid_o=0, viol_id_o=0, viol_ts_o=0, drop_cnt_o=0, irq_o=0. prev, pending and ts_cnt are 0.
- Edge on monitor_i in cycle t → pending at t+1 → push at end of t+1 (if highest priority and not full) → viol_valid_o=1 in cycle t+2. Minimum latency is 2 cycles.
- irq_o follows FIFO non-empty by one further cycle (t+3).
- ts recorded = ts_cnt value in the push cycle, which is edge cycle + 1 when uncontended.
- Throughput: 1 record/cycle sustained with viol_ready_i held at 1.
- Reset asserted mid-operation: all state is cleared immediately (asynchronously); the first edge detection is in the first cycle after release, and rules already high at release do fire, since prev=0.

## Configuration
- RM_VIOL_TIMESTAMP_EN defined: ts_cnt and the FIFO timestamp field are built, and viol_ts_o carries the captured count.
- Undefined: no counter or timestamp storage; viol_ts_o is tied to 0; every other behaviour is identical.

## Test plan
- Single edge: mask all 1, monitor_i[37] 0→1 in cycle 10, ready=1 → viol_valid_o=1 in cycle 12 with id=37, ts=11; irq_o=1 in cycle 13; monitor held high produces no second record.
- Priority: bits 5, 100 and 148 rise in the same cycle, ready=1 → records 5, 100, 148 in consecutive cycles, ts spaced by 1.
- Backpressure/full: ready=0, 10 distinct rules rise one per cycle, FIFO_DEPTH=8 → 8 records queued, 2 held pending, drop_cnt_o=0. Then ready=1 → all 10 records delivered in index/arrival order.
- Drop: ready=0, FIFO full, rule 3 pending; rule 3 falls and rises again → drop_cnt_o=1, irq_o stays 1 after the FIFO drains.
- Mask/enable/clear: mask_i[20]=0 with an edge on 20 → no record. clear_i with 3 queued → viol_valid_o=0 next cycle and drop_cnt_o=0; rules still high do not re-fire.
- Async reset mid-stream with 4 queued → all outputs 0 immediately. Macro off → viol_ts_o=0 on every record.
